reg_bank_responder: RTL and testbench
=====================================

Name: reg_bank_responder

Overview:
- Responder side of the PS→PL register access path. Accepts single read/write requests from the bus initiator and holds a bank of NREG registers of width DW. Returns one response per request.
- Register contents are exported flat to PL logic, with a one-cycle write pulse per register so downstream blocks can react to updates.

Parameters:
- DW, 32, register and data width; must be a multiple of 8.
- AW, 4, request word-address width.
- NREG, 8, number of implemented registers; must be ≤ 2^AW.

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- req_wstrb  in  DW/8  byte enables for writes
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  DW  read data (0 for writes and errors)
- rsp_err  out  1  address ≥ NREG
- reg_q  out  NREG*DW  register contents; register i at bits [i*DW +: DW]
- reg_wr_pulse  out  NREG  one-cycle pulse, bit i set the cycle after register i is written

Behaviour:
- Reset (RSTn low, asynchronous): state = IDLE, all registers 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, reg_wr_pulse = 0.
- Reset release is synchronous to CLK.
- FSM has two states, IDLE and RESP.
- IDLE:
  - req_ready = 1, rsp_valid = 0.
  - Request accepted on a rising edge where req_valid & req_ready.
  - On accept, the FSM moves to RESP.
- Accept edge actions:
  - Write, addr < NREG: each byte b with req_wstrb[b] = 1 is written from req_wdata. Other bytes keep their value.
  - Write with wstrb = 0: register unchanged, but reg_wr_pulse[addr] still fires.
  - Read, addr < NREG: rsp_rdata captures the register value as it was before this edge.
  - Addr ≥ NREG: no register changes, rsp_rdata = 0, rsp_err = 1.
  - Valid access: rsp_err = 0.
  - Any write: rsp_rdata = 0.
- RESP:
  - req_ready = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until the handshake.
  - On rsp_valid & rsp_ready, the FSM returns to IDLE.
  - rsp_valid drops the next cycle. rsp_rdata and rsp_err hold their last value (not cleared).
- Latency: response is valid the cycle after accept. Minimum request-to-request spacing is 2 cycles (one outstanding transaction, no pipelining).
- If rsp_ready is already high when RESP is entered, the response completes in one cycle.
- req_valid while in RESP is ignored (not accepted). The initiator must hold the request until req_ready.
- reg_wr_pulse[i] is registered. It is high for exactly one cycle, the cycle after the accept edge of a valid write to i. It coincides with the first rsp_valid cycle.
- reg_q reflects the new register value from the cycle after the write accept.
- Read-after-write: a read accepted after a write's response returns the written value.
- Reset mid-transaction: the response is discarded, the FSM returns to IDLE and all registers clear. The initiator must treat the transaction as lost.
- Address decoding compares the full AW bits. Aliasing is not permitted.

Test Plan:
- Reset → req_ready=1, rsp_valid=0, reg_q all 0. Read addr 3 → rsp_rdata=0x00000000, rsp_err=0, rsp_valid exactly 1 cycle after accept.
- Write addr 2, wdata=0xDEADBEEF, wstrb=4'b1111, rsp_ready=1 → reg_wr_pulse=8'b0000_0100 for 1 cycle; then read addr 2 → 0xDEADBEEF.
- Write addr 2, wdata=0x11223344, wstrb=4'b0101 (over 0xDEADBEEF) → read returns 0xDE22BE44.
- Read addr 9 (NREG=8) → rsp_err=1, rsp_rdata=0. Write addr 12 → rsp_err=1, no reg_wr_pulse, reg_q unchanged.
- Back-pressure: rsp_ready=0 for 5 cycles after a read of addr 1 → rsp_valid held, rdata stable, req_ready=0. A second req_valid asserted meanwhile is accepted only after the response handshake.
- Assert RSTn=0 while in RESP holding data 0xDEADBEEF → rsp_valid=0 immediately, reg_q=0. After release, a read of that address returns 0.

Source files
------------

// File: rtl/reg_bank_responder.sv
// Single-outstanding register-bank responder for the PS-to-PL access path.
// It holds NREG registers of width DW, answers each request once, and exports the bank to PL logic.
module reg_bank_responder #(
   parameter int unsigned DW   = 32,
   parameter int unsigned AW   = 4,
   parameter int unsigned NREG = 8
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_wr,
   input  logic [AW-1:0]      req_addr,
   input  logic [DW-1:0]      req_wdata,
   input  logic [DW/8-1:0]    req_wstrb,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic [NREG*DW-1:0] reg_q,
   output logic [NREG-1:0]    reg_wr_pulse
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t          state;
   logic [DW-1:0]   regs [NREG];
   logic [NREG-1:0] hit;
   logic            addr_ok;
   logic [DW-1:0]   rd_word;

   // Full-width address compare, so addresses at or above NREG never alias onto a register.
   always_comb begin
      hit     = '0;
      rd_word = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (req_addr == AW'(i)) begin
            hit[i]  = 1'b1;
            rd_word = regs[i];
         end
      end
   end

   assign addr_ok = |hit;

   for (genvar g = 0; g < NREG; g++) begin : g_export
      assign reg_q[g*DW +: DW] = regs[g];
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         reg_wr_pulse <= '0;
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         reg_wr_pulse <= '0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= RESP;
                  req_ready <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !addr_ok;
                  rsp_rdata <= (addr_ok && !req_wr) ? rd_word : '0;
                  if (req_wr) begin
                     // The pulse fires even when no strobe bit is set.
                     reg_wr_pulse <= hit;
                     for (int unsigned i = 0; i < NREG; i++) begin
                        for (int unsigned b = 0; b < DW/8; b++) begin
                           if (hit[i] && req_wstrb[b]) begin
                              regs[i][b*8 +: 8] <= req_wdata[b*8 +: 8];
                           end
                        end
                     end
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_responder.sv
// Directed self-checking bench for reg_bank_responder.
// It uses the default configuration: DW=32, AW=4, NREG=8.
module tb_reg_bank_responder;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 4;
   localparam int unsigned NREG = 8;

   logic               CLK;
   logic               RSTn;
   logic               req_valid;
   logic               req_ready;
   logic               req_wr;
   logic [AW-1:0]      req_addr;
   logic [DW-1:0]      req_wdata;
   logic [DW/8-1:0]    req_wstrb;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic [NREG*DW-1:0] reg_q;
   logic [NREG-1:0]    reg_wr_pulse;

   int checks = 0;
   int errors = 0;
   logic [NREG*DW-1:0] exp_q;

   reg_bank_responder #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_wstrb    (req_wstrb),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .reg_q        (reg_q),
      .reg_wr_pulse (reg_wr_pulse)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Present a request, wait for its accept edge, then drop req_valid 1 ns after that edge.
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW/8-1:0] wstrb);
      int n;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      n = 0;
      forever begin
         @(negedge CLK);
         if (req_ready === 1'b1) break;
         n++;
         if (n > 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
            break;
         end
      end
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic complete();
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      #12;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      checks++;
      if (reg_q !== '0) begin errors++; $display("FAIL rst_reg_q: got %h want 0", reg_q); end
      checks++;
      if (reg_wr_pulse !== '0) begin errors++; $display("FAIL rst_pulse: got %b want 0", reg_wr_pulse); end
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_read_after_reset();
      rsp_ready = 1'b0;
      issue(1'b0, 4'd3, 32'h0, 4'h0);
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd3_valid: got %b want 1", rsp_valid); end
      checks++;
      if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rd3_rdata: got %h want 0", rsp_rdata); end
      checks++;
      if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd3_err: got %b want 0", rsp_err); end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL rd3_ready: got %b want 0", req_ready); end
      complete();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd3_drop: got %b want 0", rsp_valid); end
   endtask

   task automatic test_write_full();
      rsp_ready = 1'b1;
      issue(1'b1, 4'd2, 32'hDEADBEEF, 4'hF);
      checks++;
      if (reg_wr_pulse !== 8'b0000_0100) begin
         errors++; $display("FAIL wr2_pulse: got %b want 00000100", reg_wr_pulse);
      end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr2_valid: got %b want 1", rsp_valid); end
      checks++;
      if (reg_q[2*DW +: DW] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wr2_reg_q: got %h want deadbeef", reg_q[2*DW +: DW]);
      end
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
      checks++;
      if (reg_wr_pulse !== '0) begin errors++; $display("FAIL wr2_pulse_off: got %b want 0", reg_wr_pulse); end
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr2_one_cycle: got %b want 0", rsp_valid); end
      issue(1'b0, 4'd2, 32'h0, 4'h0);
      checks++;
      if (rsp_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd2_rdata: got %h want deadbeef", rsp_rdata);
      end
      complete();
   endtask

   task automatic test_partial_write();
      rsp_ready = 1'b0;
      issue(1'b1, 4'd2, 32'h11223344, 4'b0101);
      checks++;
      if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL pw_rdata: got %h want 0", rsp_rdata); end
      complete();
      issue(1'b0, 4'd2, 32'h0, 4'h0);
      checks++;
      if (rsp_rdata !== 32'hDE22BE44) begin
         errors++; $display("FAIL pw_read: got %h want de22be44", rsp_rdata);
      end
      complete();
   endtask

   task automatic test_errors();
      exp_q = '0;
      exp_q[2*DW +: DW] = 32'hDE22BE44;
      issue(1'b0, 4'd9, 32'h0, 4'h0);
      checks++;
      if (rsp_err !== 1'b1) begin errors++; $display("FAIL rd9_err: got %b want 1", rsp_err); end
      checks++;
      if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rd9_rdata: got %h want 0", rsp_rdata); end
      complete();
      issue(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF);
      checks++;
      if (rsp_err !== 1'b1) begin errors++; $display("FAIL wr12_err: got %b want 1", rsp_err); end
      checks++;
      if (reg_wr_pulse !== '0) begin errors++; $display("FAIL wr12_pulse: got %b want 0", reg_wr_pulse); end
      checks++;
      if (reg_q !== exp_q) begin errors++; $display("FAIL wr12_reg_q: got %h want %h", reg_q, exp_q); end
      complete();
      issue(1'b1, 4'd10, 32'hFFFFFFFF, 4'hF);
      checks++;
      if (reg_q !== exp_q) begin errors++; $display("FAIL wr10_alias: got %h want %h", reg_q, exp_q); end
      complete();
   endtask

   task automatic test_zero_strobe();
      issue(1'b1, 4'd2, 32'hFFFFFFFF, 4'h0);
      checks++;
      if (reg_wr_pulse !== 8'b0000_0100) begin
         errors++; $display("FAIL zs_pulse: got %b want 00000100", reg_wr_pulse);
      end
      checks++;
      if (reg_q[2*DW +: DW] !== 32'hDE22BE44) begin
         errors++; $display("FAIL zs_keep: got %h want de22be44", reg_q[2*DW +: DW]);
      end
      complete();
   endtask

   task automatic test_back_pressure();
      rsp_ready = 1'b0;
      issue(1'b1, 4'd1, 32'hCAFEF00D, 4'hF);
      complete();
      issue(1'b0, 4'd1, 32'h0, 4'h0);
      // Second request waits on req_ready while the first response is stalled.
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 4'd2;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b want 1 cafef00d 0", i,
                     rsp_valid, rsp_rdata, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL bp_handshake: valid=%b ready=%b rdata=%h want 0 1 cafef00d", rsp_valid,
                  req_ready, rsp_rdata);
      end
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44) begin
         errors++;
         $display("FAIL bp_second: valid=%b rdata=%h want 1 de22be44", rsp_valid, rsp_rdata);
      end
      complete();
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
      complete();
      issue(1'b0, 4'd5, 32'h0, 4'h0);
      checks++;
      if (rsp_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rm_pre: got %h want deadbeef", rsp_rdata);
      end
      #2;
      RSTn = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rm_async: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
      checks++;
      if (reg_q !== '0) begin errors++; $display("FAIL rm_reg_q: got %h want 0", reg_q); end
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      issue(1'b0, 4'd5, 32'h0, 4'h0);
      checks++;
      if (rsp_rdata !== 32'h0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL rm_read: rdata=%h valid=%b want 0 1", rsp_rdata, rsp_valid);
      end
      complete();
   endtask

   initial begin
      RSTn      = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_read_after_reset();
      test_write_full();
      test_partial_write();
      test_errors();
      test_zero_strobe();
      test_back_pressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
